// File: rtl/fetch_decouple_queue.sv
// Decoupling FIFO between decode and rename: buffers dual-instruction bundles in order,
// absorbs rename back-pressure, and empties on flush.
module fetch_decouple_queue #(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = 192,
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                 core_clock_i,
   input  logic                 core_reset_n_i,
   input  logic                 flush_i,
   input  logic                 enq_valid_i,
   input  logic [PAYLOAD_W-1:0] enq_data_i,
   output logic                 enq_busy_o,
   output logic                 deq_valid_o,
   output logic [PAYLOAD_W-1:0] deq_data_o,
   input  logic                 deq_busy_i,
   output logic [CNT_W-1:0]     count_o,
   output logic [31:0]          stall_cnt_o
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: a transfer happens on a clock edge where the sender's valid is high and the
   // receiver's busy is low; busy never depends on the same-cycle valid, and flush cancels both.

   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     wr_ptr_nxt, rd_ptr_nxt;
   logic                 empty, full;
   logic                 enq_fire, deq_fire;
   logic                 load_head;
   logic [PAYLOAD_W-1:0] head_nxt;

   // Wrap bit distinguishes full from empty when the low index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   assign enq_busy_o  = full;
   assign deq_valid_o = !empty;
   assign count_o     = wr_ptr - rd_ptr;

   assign enq_fire = enq_valid_i && !full && !flush_i;
   assign deq_fire = !empty && !deq_busy_i && !flush_i;

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (flush_i) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (enq_fire) wr_ptr_nxt = wr_ptr + CNT_W'(1);
         if (deq_fire) rd_ptr_nxt = rd_ptr + CNT_W'(1);
      end
   end

   // The head register holds what mem[rd_ptr] will contain after this edge; when the slot
   // being written is the new head, the incoming bundle is taken directly.
   always_comb begin
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
      if (enq_fire && (rd_ptr_nxt == wr_ptr)) head_nxt = enq_data_i;
      load_head = !flush_i && (rd_ptr_nxt != wr_ptr_nxt);
   end

   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
      end
   end

   always_ff @(posedge core_clock_i) begin
      if (enq_fire) mem[wr_ptr[AW-1:0]] <= enq_data_i;
   end

   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         deq_data_o <= '0;
      end else if (load_head) begin
         deq_data_o <= head_nxt;
      end
   end

   // Frontend stall cycles; survives flush, saturates instead of wrapping.
   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         stall_cnt_o <= '0;
      end else if (enq_valid_i && full && !flush_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_decouple_queue.sv
// Directed bench for fetch_decouple_queue: reset, fill/stall, drain order, streaming,
// flush and pointer wrap, checked against hand values and an in-order expected queue.
module tb_fetch_decouple_queue;

   localparam int DEPTH = 4;
   localparam int PW    = 192;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          enq_valid;
   logic [PW-1:0] enq_data;
   logic          enq_busy;
   logic          deq_valid;
   logic [PW-1:0] deq_data;
   logic          deq_busy;
   logic [CW-1:0] count;
   logic [31:0]   stall;

   int            errors = 0;
   int            checks = 0;
   logic [PW-1:0] exp_q[$];
   int            exp_count = 0;
   logic [31:0]   exp_stall = 0;

   fetch_decouple_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
      .core_clock_i   (clk),
      .core_reset_n_i (rst_n),
      .flush_i        (flush),
      .enq_valid_i    (enq_valid),
      .enq_data_i     (enq_data),
      .enq_busy_o     (enq_busy),
      .deq_valid_o    (deq_valid),
      .deq_data_o     (deq_data),
      .deq_busy_i     (deq_busy),
      .count_o        (count),
      .stall_cnt_o    (stall)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] pat(input logic [31:0] k);
      return {6{k}};
   endfunction

   // One clock with the currently driven inputs; the expected queue tracks what rename must see.
   task automatic cycle();
      logic enq_ok, deq_ok;
      enq_ok = enq_valid && !flush && (exp_count != DEPTH);
      deq_ok = (exp_count != 0) && !deq_busy && !flush;
      check("deq_valid", PW'(deq_valid), PW'(exp_count != 0));
      check("enq_busy", PW'(enq_busy), PW'(exp_count == DEPTH));
      if (exp_count != 0) check("head", deq_data, exp_q[0]);
      if (enq_valid && (exp_count == DEPTH) && !flush && (exp_stall != 32'hFFFF_FFFF))
         exp_stall++;
      if (flush) begin
         exp_q.delete();
         exp_count = 0;
      end else begin
         if (deq_ok) begin
            void'(exp_q.pop_front());
            exp_count--;
         end
         if (enq_ok) begin
            exp_q.push_back(enq_data);
            exp_count++;
         end
      end
      @(posedge clk);
      #1;
      check("count", PW'(count), PW'(exp_count));
      check("stall_cnt", PW'(stall), PW'(exp_stall));
   endtask

   initial begin
      logic [PW-1:0] hand [5];
      int sent;
      int dut_deqs;

      rst_n     = 1'b0;
      flush     = 1'b0;
      enq_valid = 1'b0;
      enq_data  = '0;
      deq_busy  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_deq_valid", PW'(deq_valid), PW'(0));
      check("rst_enq_busy", PW'(enq_busy), PW'(0));
      check("rst_count", PW'(count), PW'(0));
      check("rst_stall", PW'(stall), PW'(0));
      check("rst_data", deq_data, PW'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fill A..D with rename stalled
      for (int i = 0; i < 5; i++) hand[i] = pat(32'hA000_0000 + 32'(i));
      deq_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         enq_valid = 1'b1;
         enq_data  = hand[i];
         cycle();
         check("fill_count", PW'(count), PW'(i + 1));
      end
      check("full_busy", PW'(enq_busy), PW'(1));
      check("full_head", deq_data, hand[0]);
      enq_data = hand[4];
      repeat (3) cycle();
      check("stall_three", PW'(stall), PW'(3));
      check("held_count", PW'(count), PW'(4));

      // drain: E refused on the busy-drop cycle, accepted on the next
      deq_busy = 1'b0;
      check("drain_a", deq_data, hand[0]);
      cycle();
      check("stall_four", PW'(stall), PW'(4));
      check("busy_dropped", PW'(enq_busy), PW'(0));
      check("drain_b", deq_data, hand[1]);
      cycle();
      check("count_after_swap", PW'(count), PW'(3));
      enq_valid = 1'b0;
      for (int k = 2; k < 5; k++) begin
         check("drain_valid", PW'(deq_valid), PW'(1));
         check("drain_order", deq_data, hand[k]);
         cycle();
      end
      check("drained", PW'(count), PW'(0));

      // streaming
      enq_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         enq_data = pat(32'h5000_0000 + 32'(i));
         if (i > 0) check("stream_data", deq_data, pat(32'h5000_0000 + 32'(i - 1)));
         cycle();
         check("stream_count", PW'(count), PW'(1));
      end
      enq_valid = 1'b0;
      cycle();

      // flush with enq and deq both requesting
      deq_busy  = 1'b1;
      enq_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         enq_data = pat(32'hF000_0000 + 32'(i));
         cycle();
      end
      check("pre_flush_count", PW'(count), PW'(3));
      flush    = 1'b1;
      deq_busy = 1'b0;
      enq_data = pat(32'hBAD0_0001);
      cycle();
      flush = 1'b0;
      check("flush_count", PW'(count), PW'(0));
      check("flush_valid", PW'(deq_valid), PW'(0));
      check("flush_busy", PW'(enq_busy), PW'(0));
      enq_valid = 1'b0;
      cycle();
      enq_valid = 1'b1;
      deq_busy  = 1'b1;
      enq_data  = pat(32'hC0DE_0000);
      cycle();
      enq_valid = 1'b0;
      check("post_flush_head", deq_data, pat(32'hC0DE_0000));
      deq_busy = 1'b0;
      cycle();

      // wrap: 3*DEPTH bundles with random back-pressure
      sent     = 0;
      dut_deqs = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if ((sent >= 3 * DEPTH) && (exp_count == 0)) break;
         enq_valid = (sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
         enq_data  = pat(32'h7700_0000 + 32'(sent));
         deq_busy  = ($urandom_range(0, 1) == 1);
         if (enq_valid && (exp_count != DEPTH)) sent++;
         if (deq_valid && !deq_busy) dut_deqs++;
         cycle();
         check("count_bound", PW'(count > CW'(DEPTH)), PW'(0));
      end
      check("wrap_deqs", PW'(dut_deqs), PW'(3 * DEPTH));
      check("wrap_empty", PW'(deq_valid), PW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
